// File: rtl/src_scheduler_pkg.sv
// Shared FSM encoding, field widths and build defaults (N_SRC, SCHED_TIMEOUT)
// for the weighted round-robin source scheduler.
`ifndef N_SRC
`define N_SRC 4
`endif
`ifndef SCHED_TIMEOUT
`define SCHED_TIMEOUT 1023
`endif

package src_scheduler_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int WEIGHT_W = 4;
   localparam int WDOG_W   = 10;
   localparam int STAT_W   = 16;
endpackage

// File: rtl/src_scheduler_rr_pick.sv
// Wrap-around first-eligible search: returns the first set bit of eligible
// at or after ptr, modulo N.
module rr_pick
   import src_scheduler_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   int j;

   // Walk from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (eligible[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/src_scheduler.sv
// Weighted round-robin scheduler granting one message source at a time to the
// command encoder, with a per-grant watchdog. Optional SCHED_STATS_EN adds stat_bus.
//
// state   | meaning
// IDLE    | no grant open, searching from ptr for an eligible source
// GRANT   | grant held, waiting for pkt_done or watchdog expiry
// RELEASE | one cycle of post-packet bookkeeping (back-to-back or hand-off)
module src_scheduler
   import src_scheduler_pkg::*;
#(
   parameter  int N_SRC   = `N_SRC,
   parameter  int TIMEOUT = `SCHED_TIMEOUT,
   localparam int IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [N_SRC-1:0]           req_bus,
   input  logic [WEIGHT_W*N_SRC-1:0]  weight_bus,
   input  logic                       pkt_done,
   input  logic                       err_clr,
   output logic [N_SRC-1:0]           have_msg_bus,
   output logic [IW-1:0]              grant_idx,
   output logic                       grant_valid,
   output logic [N_SRC-1:0]           timeout_err
`ifdef SCHED_STATS_EN
   ,
   output logic [STAT_W*N_SRC-1:0]    stat_bus
`endif
);

   state_t              state, state_n;
   logic [IW-1:0]       ptr, ptr_n;
   logic [IW-1:0]       grant_idx_n;
   logic                grant_valid_n;
   logic [N_SRC-1:0]    have_msg_n;
   logic [WEIGHT_W-1:0] credit, credit_n;
   logic [WDOG_W-1:0]   wdog, wdog_n;
   logic [N_SRC-1:0]    timeout_err_n;

   logic [WEIGHT_W-1:0] weight [N_SRC];
   logic [N_SRC-1:0]    eligible;
   logic [IW-1:0]       pick_idx;
   logic                pick_found;
   logic [N_SRC-1:0]    pick_mask;
   logic [N_SRC-1:0]    grant_mask;
   logic [IW-1:0]       ptr_after;
   logic                do_release;

   for (genvar i = 0; i < N_SRC; i++) begin : g_weight
      assign weight[i]   = weight_bus[WEIGHT_W*i +: WEIGHT_W];
      assign eligible[i] = req_bus[i] & (weight_bus[WEIGHT_W*i +: WEIGHT_W] != '0);
   end

   rr_pick #(.N(N_SRC)) u_rr_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .idx      (pick_idx),
      .found    (pick_found)
   );

   assign pick_mask  = N_SRC'(1) << pick_idx;
   assign grant_mask = N_SRC'(1) << grant_idx;
   assign ptr_after  = (grant_idx == IW'(N_SRC - 1)) ? '0 : grant_idx + IW'(1);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         ptr          <= '0;
         grant_idx    <= '0;
         grant_valid  <= 1'b0;
         have_msg_bus <= '0;
         credit       <= '0;
         wdog         <= '0;
         timeout_err  <= '0;
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         grant_idx    <= grant_idx_n;
         grant_valid  <= grant_valid_n;
         have_msg_bus <= have_msg_n;
         credit       <= credit_n;
         wdog         <= wdog_n;
         timeout_err  <= timeout_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      ptr_n         = ptr;
      grant_idx_n   = grant_idx;
      grant_valid_n = grant_valid;
      have_msg_n    = have_msg_bus;
      credit_n      = credit;
      wdog_n        = wdog;
      timeout_err_n = err_clr ? '0 : timeout_err;
      do_release    = 1'b0;

      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_idx_n   = pick_idx;
               credit_n      = weight[pick_idx] - WEIGHT_W'(1);
               grant_valid_n = 1'b1;
               have_msg_n    = req_bus & pick_mask;
               wdog_n        = '0;
               state_n       = GRANT;
            end
         end
         GRANT: begin
            // pkt_done outranks a watchdog expiry landing on the same cycle
            if (pkt_done) begin
               have_msg_n = '0;
               wdog_n     = '0;
               state_n    = RELEASE;
            end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
               timeout_err_n[grant_idx] = 1'b1;
               do_release               = 1'b1;
            end else begin
               wdog_n     = wdog + WDOG_W'(1);
               have_msg_n = req_bus & grant_mask;
            end
         end
         RELEASE: begin
            // A weight dropped to 0 during the packet also ends the round early.
            if (credit != '0 && req_bus[grant_idx] && weight[grant_idx] != '0) begin
               credit_n   = credit - WEIGHT_W'(1);
               have_msg_n = req_bus & grant_mask;
               state_n    = GRANT;
            end else begin
               do_release = 1'b1;
            end
         end
         default: begin
            do_release = 1'b1;
         end
      endcase

      if (do_release) begin
         ptr_n         = ptr_after;
         grant_valid_n = 1'b0;
         have_msg_n    = '0;
         credit_n      = '0;
         wdog_n        = '0;
         state_n       = IDLE;
      end
   end

`ifdef SCHED_STATS_EN
   logic [STAT_W-1:0] pkt_cnt [N_SRC];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < N_SRC; i++) begin
            pkt_cnt[i] <= '0;
         end
      end else if (state == GRANT && pkt_done) begin
         pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + STAT_W'(1);
      end
   end

   for (genvar i = 0; i < N_SRC; i++) begin : g_stat
      assign stat_bus[STAT_W*i +: STAT_W] = pkt_cnt[i];
   end
`endif

endmodule

// File: tb/tb_src_scheduler.sv
// Directed self-checking bench for src_scheduler (default N_SRC=4, TIMEOUT=1023).
module tb_src_scheduler;

   localparam int TO = 1023;

   logic        clk;
   logic        n_rst;
   logic [3:0]  req_bus;
   logic [15:0] weight_bus;
   logic        pkt_done;
   logic        err_clr;
   logic [3:0]  have_msg_bus;
   logic [1:0]  grant_idx;
   logic        grant_valid;
   logic [3:0]  timeout_err;
`ifdef SCHED_STATS_EN
   logic [63:0] stat_bus;
`endif

   int total = 0;
   int bad   = 0;

   src_scheduler dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req_bus      (req_bus),
      .weight_bus   (weight_bus),
      .pkt_done     (pkt_done),
      .err_clr      (err_clr),
      .have_msg_bus (have_msg_bus),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid),
      .timeout_err  (timeout_err)
`ifdef SCHED_STATS_EN
      ,
      .stat_bus     (stat_bus)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      n_rst      = 1'b0;
      req_bus    = '0;
      weight_bus = 16'h1111;
      pkt_done   = 1'b0;
      err_clr    = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst      = 1'b0;
      req_bus    = '0;
      weight_bus = 16'h1111;
      pkt_done   = 1'b0;
      err_clr    = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({have_msg_bus, grant_idx, grant_valid, timeout_err} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h expected=0",
                  {have_msg_bus, grant_idx, grant_valid, timeout_err});
      end
      n_rst    = 1'b1;
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      @(negedge clk);
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_pkt_done got=%b expected=0", grant_valid);
      end
   endtask

   task automatic test_single_grant();
      do_reset();
      req_bus = 4'b0100;
      @(negedge clk);
      total++;
      if ({grant_valid, grant_idx, have_msg_bus} !== {1'b1, 2'd2, 4'b0100}) begin
         bad++;
         $display("FAIL single_grant got=%b/%0d/%b expected=1/2/0100",
                  grant_valid, grant_idx, have_msg_bus);
      end
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      req_bus  = '0;
      total++;
      if ({grant_valid, have_msg_bus} !== {1'b1, 4'b0000}) begin
         bad++;
         $display("FAIL single_release got=%b/%b expected=1/0000", grant_valid, have_msg_bus);
      end
      @(negedge clk);
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_idle got=%b expected=0", grant_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req_bus = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if ({grant_valid, grant_idx} !== {1'b1, order[k]}) begin
            bad++;
            $display("FAIL rr_order[%0d] got=%b/%0d expected=1/%0d",
                     k, grant_valid, grant_idx, order[k]);
         end
         pkt_done = 1'b1;
         @(negedge clk);
         pkt_done = 1'b0;
         @(negedge clk);
      end
      req_bus = '0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      weight_bus = 16'h1131;
      req_bus    = 4'b0010;
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         total++;
         if ({grant_valid, grant_idx, have_msg_bus} !== {1'b1, 2'd1, 4'b0010}) begin
            bad++;
            $display("FAIL b2b_grant[%0d] got=%b/%0d/%b expected=1/1/0010",
                     g, grant_valid, grant_idx, have_msg_bus);
         end
         pkt_done = 1'b1;
         @(negedge clk);
         pkt_done = 1'b0;
      end
      @(negedge clk);
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end got=%b expected=0", grant_valid);
      end
      req_bus = 4'b0110;
      @(negedge clk);
      total++;
      if ({grant_valid, grant_idx} !== {1'b1, 2'd2}) begin
         bad++;
         $display("FAIL b2b_ptr got=%b/%0d expected=1/2", grant_valid, grant_idx);
      end
      req_bus = '0;
   endtask

   task automatic test_disabled();
      logic seen = 1'b0;
      do_reset();
      weight_bus = 16'h1110;
      req_bus    = 4'b0001;
      repeat (20) begin
         @(negedge clk);
         seen = seen | grant_valid;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL disabled_src got=%b expected=0", seen);
      end
      req_bus = 4'b0011;
      @(negedge clk);
      total++;
      if ({grant_valid, grant_idx} !== {1'b1, 2'd1}) begin
         bad++;
         $display("FAIL disabled_skip got=%b/%0d expected=1/1", grant_valid, grant_idx);
      end
      req_bus = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req_bus = 4'b1000;
      @(negedge clk);
      total++;
      if ({grant_valid, grant_idx} !== {1'b1, 2'd3}) begin
         bad++;
         $display("FAIL to_grant got=%b/%0d expected=1/3", grant_valid, grant_idx);
      end
      repeat (TO - 1) @(negedge clk);
      total++;
      if ({grant_valid, timeout_err} !== {1'b1, 4'b0000}) begin
         bad++;
         $display("FAIL to_before got=%b/%b expected=1/0000", grant_valid, timeout_err);
      end
      @(negedge clk);
      total++;
      if ({grant_valid, timeout_err, have_msg_bus} !== {1'b0, 4'b1000, 4'b0000}) begin
         bad++;
         $display("FAIL to_expire got=%b/%b/%b expected=0/1000/0000",
                  grant_valid, timeout_err, have_msg_bus);
      end
      // ptr has wrapped to 0: src0 and src3 both request, src0 must win
      req_bus = 4'b1001;
      @(negedge clk);
      req_bus = 4'b0001;
      total++;
      if ({grant_valid, grant_idx} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL to_ptr_wrap got=%b/%0d expected=1/0", grant_valid, grant_idx);
      end
      repeat (TO - 1) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      req_bus = '0;
      total++;
      if ({grant_valid, timeout_err} !== {1'b0, 4'b0001}) begin
         bad++;
         $display("FAIL to_clr_vs_set got=%b/%b expected=0/0001", grant_valid, timeout_err);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      total++;
      if (timeout_err !== 4'b0000) begin
         bad++;
         $display("FAIL to_err_clr got=%b expected=0000", timeout_err);
      end
   endtask

   task automatic test_done_beats_timeout();
      do_reset();
      req_bus = 4'b0100;
      @(negedge clk);
      req_bus = 4'b0000;
      repeat (3) @(negedge clk);
      total++;
      if ({grant_valid, grant_idx, have_msg_bus} !== {1'b1, 2'd2, 4'b0000}) begin
         bad++;
         $display("FAIL req_drop_hold got=%b/%0d/%b expected=1/2/0000",
                  grant_valid, grant_idx, have_msg_bus);
      end
      repeat (TO - 4) @(negedge clk);
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      total++;
      if ({grant_valid, timeout_err} !== {1'b1, 4'b0000}) begin
         bad++;
         $display("FAIL done_beats_to got=%b/%b expected=1/0000", grant_valid, timeout_err);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      req_bus = 4'b0100;
      @(negedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      total++;
      if ({have_msg_bus, grant_idx, grant_valid, timeout_err} !== 11'd0) begin
         bad++;
         $display("FAIL async_reset got=%h expected=0",
                  {have_msg_bus, grant_idx, grant_valid, timeout_err});
      end
      @(negedge clk);
      req_bus = '0;
      n_rst   = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_round_robin();
      test_back_to_back();
      test_disabled();
      test_timeout();
      test_done_beats_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
